// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing signal bundle for regfile_sb. The master drives selects, writes and
// scoreboard commands; the slave returns read data, busy flags and scoreboard status.
interface regfile_sb_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 16
);
  localparam int unsigned AW = $clog2(NREGS);

  logic            wr_en;
  logic [AW-1:0]   wr_sel;
  logic [XLEN-1:0] wr_data;
  logic [AW-1:0]   rs1_sel;
  logic [XLEN-1:0] rs1_data;
  logic [AW-1:0]   rs2_sel;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            pend_set;
  logic [AW-1:0]   pend_sel;
  logic            flush;
  logic [AW:0]     pend_cnt;
  logic            sb_err;

  modport master (
    output wr_en, wr_sel, wr_data, rs1_sel, rs2_sel, pend_set, pend_sel, flush,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, pend_cnt, sb_err
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, rs1_sel, rs2_sel, pend_set, pend_sel, flush,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, pend_cnt, sb_err
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, hardwired-zero x0,
// optional write-to-read bypass and a per-register load-pending scoreboard.
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 16,
  parameter bit          BYPASS = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  regfile_sb_if.slave  bus
);
  localparam int unsigned AW     = $clog2(NREGS);
  localparam logic [AW:0] NregsW = (AW+1)'(NREGS);

  // x0 and selectors past the last register are never written, never pending, read as 0.
  function automatic logic f_valid(input logic [AW-1:0] sel);
    return (sel != '0) && ({1'b0, sel} < NregsW);
  endfunction

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pend;
  logic [AW:0]      r_cnt;
  logic             r_err;

  logic             w_wr_ok;
  logic             w_set_ok;
  logic             w_same;
  logic             w_set_inc;
  logic             w_wr_dec;
  logic             w_dup;
  logic [NREGS-1:0] w_pend_d;

  assign w_wr_ok  = bus.wr_en & f_valid(bus.wr_sel);
  assign w_set_ok = bus.pend_set & f_valid(bus.pend_sel);
  assign w_same   = bus.wr_sel == bus.pend_sel;

  // A set on a register written in the same cycle leaves it pending, so no decrement there.
  assign w_set_inc = w_set_ok & ~r_pend[bus.pend_sel];
  assign w_wr_dec  = w_wr_ok & r_pend[bus.wr_sel] & ~(w_set_ok & w_same);
  assign w_dup     = w_set_ok & r_pend[bus.pend_sel] & ~(w_wr_ok & w_same);

  always_comb begin
    w_pend_d = r_pend;
    if (w_wr_ok) w_pend_d[bus.wr_sel] = 1'b0;
    if (w_set_ok) w_pend_d[bus.pend_sel] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
      r_pend <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_wr_ok) r_regs[bus.wr_sel] <= bus.wr_data;
      if (bus.flush) begin
        r_pend <= '0;
        r_cnt  <= '0;
      end else begin
        r_pend <= w_pend_d;
        r_cnt  <= r_cnt + (AW+1)'(w_set_inc) - (AW+1)'(w_wr_dec);
        if (w_dup) r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.rs1_data = '0;
    bus.rs1_busy = 1'b0;
    if (f_valid(bus.rs1_sel)) begin
      if (BYPASS && w_wr_ok && (bus.wr_sel == bus.rs1_sel)) begin
        bus.rs1_data = bus.wr_data;
      end else begin
        bus.rs1_data = r_regs[bus.rs1_sel];
        bus.rs1_busy = r_pend[bus.rs1_sel];
      end
    end
  end

  always_comb begin
    bus.rs2_data = '0;
    bus.rs2_busy = 1'b0;
    if (f_valid(bus.rs2_sel)) begin
      if (BYPASS && w_wr_ok && (bus.wr_sel == bus.rs2_sel)) begin
        bus.rs2_data = bus.wr_data;
      end else begin
        bus.rs2_data = r_regs[bus.rs2_sel];
        bus.rs2_busy = r_pend[bus.rs2_sel];
      end
    end
  end

  assign bus.pend_cnt = r_cnt;
  assign bus.sb_err   = r_err;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one bypassing and one non-bypassing instance share stimulus and are
// compared against an array-based model of the register file and load scoreboard.
module tb_regfile_sb;
  logic i_clk;
  logic i_rst_n;

  regfile_sb_if #(.XLEN(32), .NREGS(16)) bus1 ();
  regfile_sb_if #(.XLEN(32), .NREGS(16)) bus0 ();

  regfile_sb #(.XLEN(32), .NREGS(16), .BYPASS(1'b1)) u_dut1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus1)
  );

  regfile_sb #(.XLEN(32), .NREGS(16), .BYPASS(1'b0)) u_dut0 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus0)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state
  logic [31:0] m_regs [16];
  bit          m_pend [16];
  bit          m_err;

  // Inputs driven this cycle
  bit          c_we;
  bit          c_ps;
  bit          c_fl;
  logic [3:0]  c_ws;
  logic [3:0]  c_psel;
  logic [31:0] c_wd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input bit byp, input logic [3:0] sel);
    if (sel == 4'd0) return 32'd0;
    if (byp && c_we && c_ws == sel) return c_wd;
    return m_regs[sel];
  endfunction

  function automatic bit exp_busy(input bit byp, input logic [3:0] sel);
    if (sel == 4'd0) return 1'b0;
    if (byp && c_we && c_ws == sel) return 1'b0;
    return m_pend[sel];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  task automatic model_edge(input bit rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
      m_err = 1'b0;
      return;
    end
    if (c_ps && c_psel != 0 && !c_fl && m_pend[c_psel] && !(c_we && c_ws == c_psel))
      m_err = 1'b1;
    if (c_we && c_ws != 0) begin
      m_regs[c_ws] = c_wd;
      m_pend[c_ws] = 1'b0;
    end
    if (c_ps && c_psel != 0) m_pend[c_psel] = 1'b1;
    if (c_fl) for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
  endtask

  task automatic step(input bit rst_n, input bit we, input logic [3:0] ws,
                      input logic [31:0] wd, input logic [3:0] s1, input logic [3:0] s2,
                      input bit ps, input logic [3:0] psel, input bit fl);
    @(negedge i_clk);
    i_rst_n = rst_n;
    c_we = we; c_ws = ws; c_wd = wd; c_ps = ps; c_psel = psel; c_fl = fl;
    bus1.wr_en = we; bus1.wr_sel = ws; bus1.wr_data = wd; bus1.rs1_sel = s1;
    bus1.rs2_sel = s2; bus1.pend_set = ps; bus1.pend_sel = psel; bus1.flush = fl;
    bus0.wr_en = we; bus0.wr_sel = ws; bus0.wr_data = wd; bus0.rs1_sel = s1;
    bus0.rs2_sel = s2; bus0.pend_set = ps; bus0.pend_sel = psel; bus0.flush = fl;
    #1;
    if (rst_n) begin
      check("b1_rs1_data", 64'(bus1.rs1_data), 64'(exp_data(1'b1, s1)));
      check("b1_rs2_data", 64'(bus1.rs2_data), 64'(exp_data(1'b1, s2)));
      check("b1_rs1_busy", 64'(bus1.rs1_busy), 64'(exp_busy(1'b1, s1)));
      check("b1_rs2_busy", 64'(bus1.rs2_busy), 64'(exp_busy(1'b1, s2)));
      check("b1_pend_cnt", 64'(bus1.pend_cnt), 64'(exp_cnt()));
      check("b1_sb_err",   64'(bus1.sb_err),   64'(m_err));
      check("b0_rs1_data", 64'(bus0.rs1_data), 64'(exp_data(1'b0, s1)));
      check("b0_rs2_data", 64'(bus0.rs2_data), 64'(exp_data(1'b0, s2)));
      check("b0_rs1_busy", 64'(bus0.rs1_busy), 64'(exp_busy(1'b0, s1)));
      check("b0_rs2_busy", 64'(bus0.rs2_busy), 64'(exp_busy(1'b0, s2)));
      check("b0_pend_cnt", 64'(bus0.pend_cnt), 64'(exp_cnt()));
      check("b0_sb_err",   64'(bus0.sb_err),   64'(m_err));
    end
    @(posedge i_clk);
    model_edge(rst_n);
  endtask

  initial begin
    i_rst_n = 1'b0;
    c_we = 0; c_ps = 0; c_fl = 0; c_ws = 0; c_psel = 0; c_wd = 0;
    bus1.wr_en = 0; bus1.wr_sel = 0; bus1.wr_data = 0; bus1.rs1_sel = 0;
    bus1.rs2_sel = 0; bus1.pend_set = 0; bus1.pend_sel = 0; bus1.flush = 0;
    bus0.wr_en = 0; bus0.wr_sel = 0; bus0.wr_data = 0; bus0.rs1_sel = 0;
    bus0.rs2_sel = 0; bus0.pend_set = 0; bus0.pend_sel = 0; bus0.flush = 0;
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 32'hFFFF_FFFF;
      m_pend[i] = 1'b1;
    end
    m_err = 1'b1;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int s = 0; s < 16; s++) step(1, 0, 0, 0, 4'(s), 4'(15 - s), 0, 0, 0);

    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 5, 5, 0, 0, 0);
    step(1, 1, 0, 32'h1234, 0, 5, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 7, 32'hA5A5A5A5, 7, 7, 0, 0, 0);
    step(1, 0, 0, 0, 7, 7, 0, 0, 0);

    step(1, 0, 0, 0, 0, 0, 1, 3, 0);
    step(1, 0, 0, 0, 3, 4, 1, 4, 0);
    step(1, 0, 0, 0, 3, 4, 0, 0, 0);
    step(1, 1, 3, 32'h55, 3, 4, 0, 0, 0);
    step(1, 0, 0, 0, 3, 4, 0, 0, 0);

    step(1, 0, 0, 0, 3, 0, 1, 3, 0);
    step(1, 0, 0, 0, 3, 0, 1, 3, 0);
    step(1, 0, 0, 0, 3, 0, 0, 0, 0);
    step(1, 1, 3, 32'h77, 3, 3, 1, 3, 0);
    step(1, 0, 0, 0, 3, 3, 0, 0, 0);

    step(1, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 2, 0);
    step(1, 0, 0, 0, 1, 2, 1, 6, 0);
    step(1, 0, 0, 0, 6, 9, 1, 9, 1);
    step(1, 0, 0, 0, 9, 1, 0, 0, 0);
    step(1, 0, 0, 0, 2, 6, 0, 0, 0);
    step(0, 1, 2, 32'hFF, 2, 2, 0, 0, 0);
    step(1, 0, 0, 0, 2, 3, 0, 0, 0);
    step(1, 1, 2, 32'h1111, 2, 2, 0, 0, 0);
    step(1, 0, 0, 0, 2, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 9) < 4), 4'($urandom_range(0, 15)), $urandom,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 9) < 3), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised, clocked register file with an integrated load scoreboard for the rv32e_minmcu core. It provides two combinational read ports and one synchronous write port, with hardwired-zero x0 and optional write-to-read bypass. A per-register pending bit tracks multi-cycle loads, so the decoder can stall on RAW hazards without a separate hazard unit. It sits between decode (reads and pending-set) and writeback (writes and pending-clear).

## Interface
- XLEN, 32, data width in bits (8..64).
- NREGS, 16, number of architectural registers (2..32; 16 for RV32E).
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see only stored values.
- AW (localparam), $clog2(NREGS), selector width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- wr_en  in  1  write strobe.
- wr_sel  in  AW  destination register.
- wr_data  in  XLEN  write value.
- rs1_sel  in  AW  read port 1 select.
- rs1_data  out  XLEN  read port 1 value.
- rs2_sel  in  AW  read port 2 select.
- rs2_data  out  XLEN  read port 2 value.
- rs1_busy  out  1  rs1_sel has a pending load not being resolved this cycle.
- rs2_busy  out  1  rs2_sel has a pending load not being resolved this cycle.
- pend_set  in  1  mark pend_sel as pending (load issued).
- pend_sel  in  AW  register to mark.
- flush  in  1  clear all pending bits (trap or abort); data is unaffected.
- pend_cnt  out  AW+1  number of pending registers.
- sb_err  out  1  sticky scoreboard protocol error.

## Operation
- Storage: NREGS x XLEN registers plus an NREGS-bit pending vector, a pending counter, and the sb_err flag.
- Reset (rst_n low at an edge): all registers, pending bits, pend_cnt and sb_err are cleared. Reset overrides every other input in that cycle.
- Write: when wr_en is high at an edge, reg[wr_sel] takes wr_data and pending[wr_sel] clears. A write to x0, or to a selector of NREGS or above, is a no-op.
- Read: rsN_data = reg[rsN_sel], combinational.
  - x0 and out-of-range selectors read 0.
  - With BYPASS=1, if wr_en is high, wr_sel equals rsN_sel and the selector is neither x0 nor out of range, rsN_data = wr_data.
- Busy: rsN_busy = pending[rsN_sel], except it is forced to 0 when:
  - BYPASS=1 and a same-cycle write targets that register, or
  - the selector is x0 or out of range.
- Pending set: pend_set at an edge sets pending[pend_sel]. Set targeting x0 or an out-of-range selector is ignored.
- Priority, same register in the same cycle:
  - flush > pend_set > write-clear.
  - If pend_set and wr_en hit the same register: data is written and the bit ends set, because a new load was issued after the old writeback.
- Flush: clears every pending bit and sets pend_cnt to 0. A concurrent pend_set is dropped. A concurrent write still updates data.
- sb_err: set (sticky until reset) when pend_set targets a register that is already pending and is not being cleared by wr_en in the same cycle, with flush low.
- pend_cnt: always equals the popcount of the pending vector after the edge. It must be maintained incrementally (+1, -1, 0, or to 0 on flush); it is never re-counted.

## Timing
- Write latency: 1 edge. With BYPASS=0, data is visible on the read ports the cycle after wr_en.
- Read latency: 0 cycles, combinational from rsN_sel, stored state, and (if BYPASS=1) wr_en/wr_sel/wr_data.
- Busy outputs: combinational. They have the same bypass dependence as the data.
- Pending set: visible on rsN_busy the cycle after pend_set.
- Pending clear: with BYPASS=1, clears in the same cycle as the write; with BYPASS=0, clears one cycle after the write.
- Reset values: rs1_data = rs2_data = 0, rs1_busy = rs2_busy = 0, pend_cnt = 0, sb_err = 0.
- Reset mid-operation: all pending loads are forgotten. A writeback arriving after reset deasserts still writes data normally.

## Test plan
- Reset, then read x0..x15 on both ports -> all 0; busy = 0; pend_cnt = 0; sb_err = 0.
- Write 0xDEADBEEF to x5; next cycle rs1_sel = 5, rs2_sel = 5 -> both read 0xDEADBEEF. Write 0x1234 to x0 -> x0 still reads 0.
- BYPASS=1: wr_en with x7 = 0xA5A5A5A5 and rs1_sel = 7 in the same cycle -> rs1_data = 0xA5A5A5A5 combinationally. Repeat with BYPASS=0 -> old value that cycle, new value the next cycle.
- pend_set x3, then x4 -> pend_cnt = 2, rs1_busy high for x3. Write x3 = 0x55 -> rs1_busy low in that cycle (BYPASS=1), pend_cnt = 1 after the edge.
- pend_set x3 twice with no writeback -> sb_err = 1 and stays 1. pend_set x3 together with wr_en x3 = 0x77 -> x3 = 0x77, x3 still pending, sb_err unaffected.
- Set x1, x2, x6 pending, then assert flush with pend_set x9 -> pend_cnt = 0, no register busy (including x9). Then assert rst_n low with wr_en x2 = 0xFF -> x2 reads 0 after reset.
